// File: rtl/condlogic_pkg.sv
// Shared definitions for the conditional-execution stage: condition codes,
// NZCV bit positions and the meaning of the decoder's FlagW bits.
package condlogic_pkg;

    // ARM condition field encodings (Instr[31:28])
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    // FlagW bits: [1] updates N,Z ; [0] updates C,V
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/condlogic_condcheck.sv
// Purely combinational condition evaluator: condition field + NZCV -> pass/fail.
// Kept free of state so a pipelined core can reuse it unchanged.
module condlogic_condcheck
    import condlogic_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n;
    logic z;
    logic c;
    logic v;
    logic ge;

    assign n  = flags[N_BIT];
    assign z  = flags[Z_BIT];
    assign c  = flags[C_BIT];
    assign v  = flags[V_BIT];
    assign ge = (n == v);

    // Decode every 4-bit condition; the NV encoding is treated as never
    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = ge;
            COND_LT: cond_ex = ~ge;
            COND_GT: cond_ex = ~z & ge;
            COND_LE: cond_ex = z | ~ge;
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/condlogic.sv
// Conditional-execution stage of the multicycle ARM core. Holds the
// architectural NZCV flags, evaluates the instruction condition against
// them and gates the decoder's PC/register/memory write requests.
module condlogic
    import condlogic_pkg::*;
#(
    parameter logic [3:0] FLAG_RESET = 4'b0000,
    parameter bit         DELAY_COND = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondEx
);

    logic [1:0] nz_q;
    logic [1:0] cv_q;
    logic       cond_ex_p1;
    logic       gate;

    assign Flags = {nz_q, cv_q};

    condlogic_condcheck u_condcheck (
        .cond    (Cond),
        .flags   (Flags),
        .cond_ex (CondEx)
    );

    // Condition result captured at the end of decode, held through exec/mem/wb
    always_ff @(posedge clk) begin
        if (!reset) begin
            cond_ex_p1 <= 1'b0;
        end else begin
            cond_ex_p1 <= CondEx;
        end
    end

    // N,Z half of the flag register; updated only by an instruction that passes
    always_ff @(posedge clk) begin
        if (!reset) begin
            nz_q <= FLAG_RESET[N_BIT:Z_BIT];
        end else if (FlagW[FLAGW_NZ] && CondEx) begin
            nz_q <= ALUFlags[N_BIT:Z_BIT];
        end
    end

    // C,V half of the flag register; updated only by an instruction that passes
    always_ff @(posedge clk) begin
        if (!reset) begin
            cv_q <= FLAG_RESET[C_BIT:V_BIT];
        end else if (FlagW[FLAGW_CV] && CondEx) begin
            cv_q <= ALUFlags[C_BIT:V_BIT];
        end
    end

    // The combinational gate exists only for debug; normal builds use the flop
    assign gate = DELAY_COND ? cond_ex_p1 : CondEx;

    // Reset low suppresses every write, even the unconditional fetch increment
    assign PCWrite  = reset & ((PCS & gate) | NextPC);
    assign RegWrite = reset & RegW & gate;
    assign MemWrite = reset & MemW & gate;

endmodule

// File: doc/condlogic.md
Name: condlogic

Overview:
- Conditional-execution stage directly downstream of the instruction decoder in the multicycle ARM core.
- Takes the decoder's raw write requests (FlagW, PCS, NextPC, RegW, MemW) and the instruction's condition field.
- Holds the architectural NZCV flags and evaluates the condition.
- Produces the gated write enables (PCWrite, RegWrite, MemWrite) that drive the datapath.

Parameters:
- FLAG_RESET, 4'b0000, NZCV value loaded into the flag register at reset.
- DELAY_COND, 1, 1 = gate PC/register/memory writes with the registered condition result; 0 = gate them with the combinational result (debug only).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets).
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  ALU result flags {N,Z,C,V} from the current cycle.
- FlagW  input  2  decoder flag-write request; [1] = N,Z and [0] = C,V.
- PCS  input  1  decoder request to write PC from the result (branch or Rd==15).
- NextPC  input  1  FSM fetch-cycle PC increment (unconditional).
- RegW  input  1  decoder register-write request.
- MemW  input  1  decoder memory-write request.
- PCWrite  output  1  gated PC enable.
- RegWrite  output  1  gated register-file write enable.
- MemWrite  output  1  gated memory write enable.
- Flags  output  4  current architectural {N,Z,C,V}.
- CondEx  output  1  combinational condition result for Cond against Flags.

Behaviour:
- Condition check is combinational on Cond and the registered Flags, never on ALUFlags.
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C.
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~C|Z.
  - 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 0 (unconditional space unsupported; treated as never).
- CondExD register: loads CondEx on every rising edge; resets to 0.
- Gate signal G = CondExD when DELAY_COND=1, else CondEx.
- Write enables are combinational:
  - PCWrite = (PCS & G) | NextPC.
  - RegWrite = RegW & G.
  - MemWrite = MemW & G.
- Flag update uses the undelayed CondEx:
  - Flags[3:2] <= ALUFlags[3:2] when FlagW[1] & CondEx.
  - Flags[1:0] <= ALUFlags[1:0] when FlagW[0] & CondEx.
  - Otherwise each half holds.
- Latency: a flag write takes effect at the next edge. In the cycle of the write, CondEx and Flags still show the old values.
- FlagW with both bits set and CondEx=1: all four flags load in the same edge.
- FlagW active and CondEx=0: no flag change.
- Reset (reset==0 at an edge): Flags <= FLAG_RESET, CondExD <= 0.
- While reset is low, PCWrite, RegWrite and MemWrite are forced to 0 combinationally, including NextPC. This guarantees no architectural write during reset.
- Reset asserted mid-instruction: any pending delayed write is dropped, because CondExD clears.
- First cycle after reset release: G=0 when DELAY_COND=1, so only NextPC can write.
- Timing relative to the main FSM:
  - Cond is stable from the decode state onward.
  - CondExD captured at the end of decode is valid through execute, memory and writeback, because flags change only in an execute cycle whose CondEx was already 1.
- No X propagation: undefined Cond values do not exist (4-bit fully decoded).

Decomposition:
- Shared package entries:
  - Condition-code constants (EQ..AL, NV).
  - Flag bit-index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
  - FlagW bit meanings.
- Sub-module condcheck: purely combinational, Cond + Flags -> CondEx; reused by any future pipelined variant.
- condlogic contains the flag register halves, the CondExD flop, reset gating and enable logic.

Test Plan:
- Reset: hold reset=0 for 2 cycles with NextPC=1, RegW=1 -> PCWrite=RegWrite=MemWrite=0. After release, Flags=FLAG_RESET (0000) and CondExD=0.
- Flag set then EQ: Cond=1110, FlagW=11, ALUFlags=0100 for 1 cycle -> next cycle Flags=0100. Then Cond=0000, RegW=1 -> CondEx=1; RegWrite=1 one cycle later (DELAY_COND=1).
- Partial write: Flags=1111, FlagW=10, ALUFlags=0000, Cond=1110 -> Flags=0011 (C,V held).
- Failed condition: Flags=0000, Cond=0000 (EQ), FlagW=11, ALUFlags=1111, MemW=1, PCS=1 -> Flags stay 0000; MemWrite=0; PCWrite=0 unless NextPC=1.
- Signed compares: Flags N=1,V=0 -> LT(1011)=1, GE(1010)=0, GT(1100)=0, LE(1101)=1. Flags Z=0,C=1 -> HI(1000)=1; Cond=1111 -> CondEx=0 for every Flags value.
- Mid-instruction reset: CondExD=1 and RegW=1 in the writeback state; assert reset=0 for one edge -> RegWrite=0 immediately, CondExD=0 and Flags=0000 after the edge.
